// File: rtl/bisr_proxy_pkg.sv
// Shared types for the BISR weight-proxy repair flow.
// Weight/magnitude typedefs and the proxy selector state encoding.
package bisr_proxy_pkg;

  localparam int WEIGHT_W = 32;

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic        [WEIGHT_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } proxy_sel_state_t;

endpackage

// File: rtl/weight_proxy_selector_if.sv
// Handshake bundle between weight buffer reader, proxy selector and repair-map controller.
// The master side drives the weight stream and acknowledges results.
interface weight_proxy_selector_if
  import bisr_proxy_pkg::*;
#(
  parameter int NUM_WEIGHTS = 16,
  parameter int IDX_W       = $clog2(NUM_WEIGHTS)
);

  logic                   start;
  logic [NUM_WEIGHTS-1:0] skip_mask;
  logic                   w_valid;
  weight_t                w_data;
  logic                   w_ready;
  logic                   busy;
  logic                   res_valid;
  logic [IDX_W-1:0]       res_idx;
  mag_t                   res_mag;
  logic                   res_none;
  logic                   res_ack;

  modport master (
    output start, skip_mask, w_valid, w_data, res_ack,
    input  w_ready, busy, res_valid, res_idx, res_mag, res_none
  );

  modport slave (
    input  start, skip_mask, w_valid, w_data, res_ack,
    output w_ready, busy, res_valid, res_idx, res_mag, res_none
  );

endinterface

// File: rtl/abs_mag_compare.sv
// Combinational |w| of a candidate weight and strict unsigned compare against the current best.
// 0x8000_0000 maps to magnitude 0x8000_0000, the largest representable one.
module abs_mag_compare
  import bisr_proxy_pkg::*;
(
  input  weight_t cand,
  input  mag_t    best_mag,
  output mag_t    cand_mag,
  output logic    cand_lt_best
);

  assign cand_mag     = cand[WEIGHT_W-1] ? (~mag_t'(cand) + mag_t'(1)) : mag_t'(cand);
  assign cand_lt_best = (cand_mag < best_mag);

endmodule

// File: rtl/weight_proxy_selector.sv
// Streaming scanner that picks the smallest-|w| eligible weight of a column as the repair proxy.
// Ties keep the lower index; masked indices are consumed but never considered.
module weight_proxy_selector
  import bisr_proxy_pkg::*;
#(
  parameter int NUM_WEIGHTS = 16,
  parameter int IDX_W       = $clog2(NUM_WEIGHTS)
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  weight_proxy_selector_if.slave   bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

  proxy_sel_state_t       state_q;
  proxy_sel_state_t       state_d;
  logic [NUM_WEIGHTS-1:0] mask_q;
  logic [IDX_W-1:0]       count_q;
  logic [IDX_W-1:0]       best_idx_q;
  mag_t                   best_mag_q;
  logic                   have_best_q;
  logic [IDX_W-1:0]       res_idx_q;
  mag_t                   res_mag_q;
  logic                   res_none_q;

  logic                   w_ready;
  logic                   busy;
  logic                   res_valid;

  mag_t                   cand_mag;
  logic                   cand_lt_best;
  logic                   xfer;
  logic                   last_xfer;
  logic                   take;
  logic                   next_have;
  logic [IDX_W-1:0]       next_idx;
  mag_t                   next_mag;

  abs_mag_compare u_cmp (
    .cand         (bus.w_data),
    .best_mag     (best_mag_q),
    .cand_mag     (cand_mag),
    .cand_lt_best (cand_lt_best)
  );

  // Best-so-far including the weight on the current transfer, so the final
  // result can be captured on the same edge as the last transfer.
  assign xfer      = bus.w_valid && (state_q == SCAN);
  assign last_xfer = xfer && (count_q == LAST_IDX);
  assign take      = xfer && !mask_q[count_q] && (!have_best_q || cand_lt_best);
  assign next_have = have_best_q || take;
  assign next_idx  = take ? count_q  : best_idx_q;
  assign next_mag  = take ? cand_mag : best_mag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_ready   = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (last_xfer) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (bus.res_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers only load on the last transfer, so they hold through
  // DONE and keep their values after the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      count_q     <= '0;
      best_idx_q  <= '0;
      best_mag_q  <= '0;
      have_best_q <= 1'b0;
      res_idx_q   <= '0;
      res_mag_q   <= '0;
      res_none_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        mask_q      <= bus.skip_mask;
        count_q     <= '0;
        best_idx_q  <= '0;
        best_mag_q  <= '0;
        have_best_q <= 1'b0;
      end
      if (xfer) begin
        count_q     <= count_q + IDX_W'(1);
        best_idx_q  <= next_idx;
        best_mag_q  <= next_mag;
        have_best_q <= next_have;
      end
      if (last_xfer) begin
        res_idx_q  <= next_have ? next_idx : '0;
        res_mag_q  <= next_have ? next_mag : '0;
        res_none_q <= !next_have;
      end
    end
  end

  assign bus.w_ready   = w_ready;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_mag   = res_mag_q;
  assign bus.res_none  = res_none_q;

endmodule

// File: doc/weight_proxy_selector.md
Name: weight_proxy_selector

Overview:
- Streaming scanner used by the BISR weight-proxy repair flow.
- Accepts the NUM_WEIGHTS signed 32-bit weights of one array column, one per handshake.
- Reports the index and magnitude of the smallest-|w| eligible weight, which becomes the proxy slot sacrificed for a faulty PE.
- Sits between the weight buffer reader and the repair-map controller; consumes magnitude comparisons rather than producing them.

Parameters:
- NUM_WEIGHTS, 16, weights per scan; must be >= 2.
- IDX_W, $clog2(NUM_WEIGHTS), width of index outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan. Ignored unless in IDLE.
- skip_mask  in  NUM_WEIGHTS  bit i=1 makes index i ineligible; sampled on the accepted start.
- w_valid  in  1  weight input valid.
- w_data  in  32  signed weight, two's complement.
- w_ready  out  1  high only in SCAN.
- busy  out  1  high in SCAN and DONE.
- res_valid  out  1  high in DONE.
- res_idx  out  IDX_W  index of the selected weight.
- res_mag  out  32  unsigned |w| of the selected weight.
- res_none  out  1  all indices masked; no eligible weight.
- res_ack  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count, res_idx and res_mag are 0; res_none=0.
  - w_ready, busy and res_valid are 0; the stored mask is 0.
- Magnitude rule:
  - mag = w_data[31] ? (~w_data + 1) : w_data, 32-bit unsigned.
  - 0x8000_0000 gives mag 0x8000_0000, the largest magnitude. It is not an error.
- FSM IDLE -> SCAN:
  - Taken on start.
  - Latch skip_mask; count=0; have_best=0.
- SCAN:
  - A transfer occurs on w_valid && w_ready. Weight k is index count.
  - On a transfer with mask[count]=0, the weight replaces the best when have_best=0 or mag < best_mag (strict).
  - On replacement: best_idx=count, best_mag=mag, have_best=1.
  - Ties keep the lower index.
  - Masked weights are consumed but never compared.
  - count increments per transfer.
  - On the transfer with count==NUM_WEIGHTS-1: go to DONE the next cycle, with res_idx/res_mag from the final best, including that last weight.
  - w_valid low stalls the scan with no state change.
- DONE:
  - res_valid=1; res_none = !have_best. When res_none=1, res_idx=0 and res_mag=0.
  - Outputs hold stable until res_ack. Then go to IDLE next cycle: res_valid=0, res_idx/res_mag retain their values.
  - Latency: res_valid asserts exactly 1 cycle after the last weight transfer.
  - res_ack in the same cycle res_valid first rises is legal.
- start while SCAN or DONE: ignored; no restart.
- start and res_ack in the same cycle in DONE: the ack is honoured, the start is dropped. A new start is needed in IDLE.
- Reset mid-scan: immediate return to reset values; partial results are discarded.
- No back-to-back start->SCAN without passing through IDLE. Minimum overhead is 1 IDLE cycle per scan.

Decomposition:
- Shared package bisr_proxy_pkg:
  - typedef weight_t (logic signed [31:0]).
  - typedef mag_t (logic [31:0]).
  - enum proxy_sel_state_t {IDLE, SCAN, DONE}.
  - Localparam WEIGHT_W=32.
- One sub-module: abs_mag_compare.
  - Combinational.
  - Outputs mag of the candidate and cand_lt_best (unsigned strict compare).
  - Keeps the arithmetic separate from the FSM.

Test Plan:
- NUM_WEIGHTS=4, mask=0, weights {5,-3,7,-9} -> res_idx=1, res_mag=3, res_none=0, res_valid 1 cycle after 4th transfer.
- Weights {-4,4,2,-2}, mask=0 -> res_idx=2, res_mag=2 (tie: lower index kept).
- Weights {0x8000_0000,0x7FFF_FFFF,-1,0}, mask=4'b1000 -> res_idx=2, res_mag=1; index 3 (value 0) is skipped.
- mask=4'b1111, any weights -> res_none=1, res_idx=0, res_mag=0; w_valid toggled 1/0 each cycle gives the same result after 4 transfers.
- rst_n pulsed low after 2 transfers -> all outputs 0 immediately; a new start and a full scan of {1,2,3,0} -> res_idx=3, res_mag=0.
- start pulsed during SCAN and during DONE, res_ack delayed 5 cycles -> no restart, res_valid held 5 cycles with stable outputs, then IDLE.
